// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and command-master state encoding.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    RSP
  } state_t;

endpackage

// File: rtl/axi4lite_master_cmd_if.sv
// AXI4-Lite bus bundle between the command master and a slave.
interface axi4lite_master_cmd_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axi4lite_wdog.sv
// Response-wait watchdog: counts enabled cycles, flags the last allowed one.
module axi4lite_wdog #(
  parameter int unsigned C_TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = (C_TIMEOUT_CYCLES < 2) ? 1 : $clog2(C_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'((C_TIMEOUT_CYCLES == 0) ? 0 : C_TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Expiry is flagged during the Nth enabled cycle so the owner leaves on that edge.
  assign expired = (C_TIMEOUT_CYCLES != 0) && enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/axi4lite_master_cmd.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response handshake.
module axi4lite_master_cmd
  import axi4lite_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES   = 256
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic                            CMD_WRITE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
  input  logic [2:0]                      CMD_PROT,
  output logic                            RSP_VALID,
  input  logic                            RSP_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                      RSP_RESP,
  output logic                            RSP_WRITE,
  output logic                            RSP_TIMEOUT,
  axi4lite_master_cmd_if.master           m_axi
);
  state_t                          state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] strb_q;
  logic [2:0]                      prot_q;
  logic awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic wait_rsp, expired;

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWPROT  = prot_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = strb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARPROT  = prot_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

  // Counter sits cleared outside the response-wait states, so entry always starts at zero.
  assign wait_rsp = (state == WRESP) || (state == RDATA);

  axi4lite_wdog #(.C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)) u_wdog (
    .clk     (M_AXI_ACLK),
    .rst     (M_AXI_ARESET),
    .clear   (!wait_rsp),
    .enable  (wait_rsp),
    .expired (expired)
  );

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state       <= IDLE;
      CMD_READY   <= 1'b1;
      bready_q    <= 1'b1;
      rready_q    <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_RESP    <= '0;
      RSP_WRITE   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            addr_q    <= CMD_ADDR;
            wdata_q   <= CMD_WDATA;
            strb_q    <= CMD_WSTRB;
            prot_q    <= CMD_PROT;
            CMD_READY <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            if (CMD_WRITE) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state     <= RADDR;
            end
          end
        end
        WADDR: begin
          if (m_axi.M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (m_axi.M_AXI_WREADY)  wvalid_q  <= 1'b0;
          // A channel already done counts as complete regardless of its READY.
          if ((!awvalid_q || m_axi.M_AXI_AWREADY) && (!wvalid_q || m_axi.M_AXI_WREADY)) begin
            bready_q <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi.M_AXI_BVALID || expired) begin
            bready_q    <= 1'b0;
            RSP_VALID   <= 1'b1;
            RSP_RDATA   <= '0;
            RSP_WRITE   <= 1'b1;
            RSP_TIMEOUT <= !m_axi.M_AXI_BVALID;
            RSP_RESP    <= m_axi.M_AXI_BVALID ? m_axi.M_AXI_BRESP : RESP_SLVERR;
            state       <= RSP;
          end
        end
        RADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi.M_AXI_RVALID || expired) begin
            rready_q    <= 1'b0;
            RSP_VALID   <= 1'b1;
            RSP_WRITE   <= 1'b0;
            RSP_TIMEOUT <= !m_axi.M_AXI_RVALID;
            RSP_RDATA   <= m_axi.M_AXI_RVALID ? m_axi.M_AXI_RDATA : '0;
            RSP_RESP    <= m_axi.M_AXI_RVALID ? m_axi.M_AXI_RRESP : RESP_SLVERR;
            state       <= RSP;
          end
        end
        RSP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            CMD_READY <= 1'b1;
            bready_q  <= 1'b1;
            rready_q  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4lite_master_cmd.sv
// Directed bench for axi4lite_master_cmd with a response scoreboard queue.
module tb_axi4lite_master_cmd;
  import axi4lite_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        write;
    logic        timeout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int unsigned total = 0, bad = 0, cyc = 0;
  int unsigned aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;
  int unsigned t0, lat, a0, w0, b0;
  exp_t        sb[$];

  axi4lite_master_cmd_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi4lite_master_cmd #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_TIMEOUT_CYCLES  (8)
  ) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARESET(rst),
    .CMD_VALID   (cmd_valid),
    .CMD_READY   (cmd_ready),
    .CMD_WRITE   (cmd_write),
    .CMD_ADDR    (cmd_addr),
    .CMD_WDATA   (cmd_wdata),
    .CMD_WSTRB   (cmd_wstrb),
    .CMD_PROT    (cmd_prot),
    .RSP_VALID   (rsp_valid),
    .RSP_READY   (rsp_ready),
    .RSP_RDATA   (rsp_rdata),
    .RSP_RESP    (rsp_resp),
    .RSP_WRITE   (rsp_write),
    .RSP_TIMEOUT (rsp_timeout),
    .m_axi       (axi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) aw_cnt <= aw_cnt + 1;
    if (axi.M_AXI_WVALID && axi.M_AXI_WREADY)   w_cnt  <= w_cnt + 1;
    if (axi.M_AXI_BVALID && axi.M_AXI_BREADY)   b_cnt  <= b_cnt + 1;
    if (axi.M_AXI_RVALID && axi.M_AXI_RREADY)   r_cnt  <= r_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_prot = p;
    t0 = cyc;
  endtask

  // Waits (bounded) for RSP_VALID, scores it against the queue head, then consumes it.
  task automatic wait_rsp(input int unsigned budget);
    exp_t e;
    int unsigned n = 0;
    while (!rsp_valid && n < budget) begin
      step();
      n++;
    end
    lat = cyc - t0;
    check("rsp_seen", 64'(rsp_valid), 64'(1));
    if (rsp_valid) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        check("rsp_write", 64'(rsp_write), 64'(e.write));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("rsp_drop", 64'(rsp_valid), 64'(0));
      check("cmd_ready_back", 64'(cmd_ready), 64'(1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_BVALID = 1'b0;  axi.M_AXI_BRESP = '0;
    axi.M_AXI_RVALID = 1'b0;  axi.M_AXI_RDATA = '0;   axi.M_AXI_RRESP = '0;

    step(); step();
    rst = 1'b0;
    step();
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_bready", 64'(axi.M_AXI_BREADY), 64'(1));
    check("rst_rready", 64'(axi.M_AXI_RREADY), 64'(1));
    check("rst_valids", 64'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID, rsp_valid}), 64'(0));
    check("rst_awaddr", 64'(axi.M_AXI_AWADDR), 64'(0));

    // Zero-wait write
    a0 = aw_cnt; w0 = w_cnt;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0);
    axi.M_AXI_AWREADY = 1'b1; axi.M_AXI_WREADY = 1'b1;
    sb.push_back('{32'h0, RESP_OKAY, 1'b1, 1'b0});
    step();
    cmd_valid = 1'b0;
    check("w1_aw_w_valid", 64'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID}), 64'(2'b11));
    check("w1_awaddr", 64'(axi.M_AXI_AWADDR), 64'(32'h10));
    check("w1_wdata", 64'(axi.M_AXI_WDATA), 64'(32'hDEADBEEF));
    check("w1_wstrb", 64'(axi.M_AXI_WSTRB), 64'(4'hF));
    check("w1_cmd_ready", 64'(cmd_ready), 64'(0));
    step();
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
    check("w1_valids_drop", 64'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID}), 64'(0));
    check("w1_bready", 64'(axi.M_AXI_BREADY), 64'(1));
    axi.M_AXI_BVALID = 1'b1; axi.M_AXI_BRESP = RESP_OKAY;
    step();
    axi.M_AXI_BVALID = 1'b0;
    wait_rsp(20);
    check("w1_latency", 64'(lat), 64'(3));
    check("w1_aw_beats", 64'(aw_cnt - a0), 64'(1));
    check("w1_w_beats", 64'(w_cnt - w0), 64'(1));

    // W accepted two cycles before AW
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    issue(1'b1, 32'h20, 32'hA5A50001, 4'h3, 3'b010);
    sb.push_back('{32'h0, RESP_EXOKAY, 1'b1, 1'b0});
    step();
    cmd_valid = 1'b0;
    axi.M_AXI_WREADY = 1'b1;
    step();
    axi.M_AXI_WREADY = 1'b0;
    check("w2_wvalid_drop", 64'(axi.M_AXI_WVALID), 64'(0));
    check("w2_awvalid_held", 64'(axi.M_AXI_AWVALID), 64'(1));
    check("w2_awprot", 64'(axi.M_AXI_AWPROT), 64'(3'b010));
    step();
    check("w2_aw_stable", 64'({axi.M_AXI_AWVALID, axi.M_AXI_AWADDR}), 64'({1'b1, 32'h20}));
    axi.M_AXI_AWREADY = 1'b1;
    step();
    axi.M_AXI_AWREADY = 1'b0;
    check("w2_awvalid_drop", 64'(axi.M_AXI_AWVALID), 64'(0));
    axi.M_AXI_BVALID = 1'b1; axi.M_AXI_BRESP = RESP_EXOKAY;
    step();
    axi.M_AXI_BVALID = 1'b0;
    wait_rsp(20);
    check("w2_beats", 64'({8'(aw_cnt - a0), 8'(w_cnt - w0), 8'(b_cnt - b0)}), 64'(24'h010101));

    // Zero-wait read with SLVERR
    issue(1'b0, 32'h24, 32'h0, 4'h0, 3'd0);
    axi.M_AXI_ARREADY = 1'b1;
    sb.push_back('{32'h12345678, RESP_SLVERR, 1'b0, 1'b0});
    step();
    cmd_valid = 1'b0;
    check("r1_arvalid", 64'(axi.M_AXI_ARVALID), 64'(1));
    check("r1_araddr", 64'(axi.M_AXI_ARADDR), 64'(32'h24));
    step();
    axi.M_AXI_ARREADY = 1'b0;
    check("r1_arvalid_drop", 64'(axi.M_AXI_ARVALID), 64'(0));
    check("r1_rready", 64'(axi.M_AXI_RREADY), 64'(1));
    axi.M_AXI_RVALID = 1'b1; axi.M_AXI_RDATA = 32'h12345678; axi.M_AXI_RRESP = RESP_SLVERR;
    step();
    axi.M_AXI_RVALID = 1'b0;
    wait_rsp(20);
    check("r1_latency", 64'(lat), 64'(3));

    // Write whose B never arrives: timeout after 8 cycles in WRESP
    issue(1'b1, 32'h30, 32'h1, 4'h1, 3'd0);
    axi.M_AXI_AWREADY = 1'b1; axi.M_AXI_WREADY = 1'b1;
    sb.push_back('{32'h0, RESP_SLVERR, 1'b1, 1'b1});
    step();
    cmd_valid = 1'b0;
    step();
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
    t0 = cyc;
    check("to_no_rsp_yet", 64'(rsp_valid), 64'(0));
    wait_rsp(30);
    check("to_wresp_cycles", 64'(lat), 64'(8));
    b0 = b_cnt;
    axi.M_AXI_BVALID = 1'b1; axi.M_AXI_BRESP = RESP_OKAY;
    step();
    axi.M_AXI_BVALID = 1'b0;
    step();
    check("to_late_b_absorbed", 64'(b_cnt - b0), 64'(1));
    check("to_late_b_no_rsp", 64'({rsp_valid, cmd_ready}), 64'(2'b01));

    // Response back-pressure
    issue(1'b0, 32'h40, 32'h0, 4'h0, 3'd0);
    axi.M_AXI_ARREADY = 1'b1;
    sb.push_back('{32'hCAFEF00D, RESP_OKAY, 1'b0, 1'b0});
    step();
    cmd_valid = 1'b0;
    step();
    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID = 1'b1; axi.M_AXI_RDATA = 32'hCAFEF00D; axi.M_AXI_RRESP = RESP_OKAY;
    step();
    axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      check("bp_rsp_rdata", 64'(rsp_rdata), 64'(32'hCAFEF00D));
      check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
      step();
    end
    wait_rsp(5);

    // Reset during RADDR abandons the read
    issue(1'b0, 32'h50, 32'h0, 4'h0, 3'd0);
    step();
    cmd_valid = 1'b0;
    check("rr_arvalid", 64'(axi.M_AXI_ARVALID), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_arvalid_cleared", 64'(axi.M_AXI_ARVALID), 64'(0));
    step();
    check("rr_idle", 64'({rsp_valid, cmd_ready, axi.M_AXI_ARVALID}), 64'(3'b010));
    axi.M_AXI_RVALID = 1'b1; axi.M_AXI_RDATA = 32'hFFFFFFFF;
    step();
    axi.M_AXI_RVALID = 1'b0;
    step();
    check("rr_stale_r_no_rsp", 64'(rsp_valid), 64'(0));
    issue(1'b0, 32'h54, 32'h0, 4'h0, 3'd1);
    axi.M_AXI_ARREADY = 1'b1;
    sb.push_back('{32'h0BADF00D, RESP_EXOKAY, 1'b0, 1'b0});
    step();
    cmd_valid = 1'b0;
    check("rr2_araddr", 64'({axi.M_AXI_ARADDR, axi.M_AXI_ARPROT}), 64'({32'h54, 3'd1}));
    step();
    axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_RVALID = 1'b1; axi.M_AXI_RDATA = 32'h0BADF00D; axi.M_AXI_RRESP = RESP_EXOKAY;
    step();
    axi.M_AXI_RVALID = 1'b0;
    wait_rsp(20);
    check("rr2_latency", 64'(lat), 64'(3));

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
